// File: rtl/output_layer_ctrl.sv
// Output-layer sequencer: one signed dot product per output neuron, streamed on valid/ready.
// Optional argmax tracking is built when OUTPUT_LAYER_CTRL_ARGMAX_EN is defined.
module output_layer_ctrl #(
    parameter int NUM_HIDDEN = 32,
    parameter int NUM_OUT    = 10,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 22,
    localparam int HID_W     = $clog2(NUM_HIDDEN),
    localparam int IDX_W     = $clog2(NUM_OUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [HID_W-1:0]      hid_addr,
    input  logic [DATA_WIDTH-1:0] hid_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_idx,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic [IDX_W-1:0]      pred_idx
);

    localparam int PROD_W = 2 * DATA_WIDTH + 1;
    localparam logic [HID_W-1:0] J_LAST = HID_W'(NUM_HIDDEN - 1);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]            k;
    logic [HID_W-1:0]            j;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] term;
    logic                        xfer;

    // Unsigned activation times signed weight, sign-extended to accumulator width.
    function automatic logic signed [ACC_WIDTH-1:0] mac_term(
        input logic [DATA_WIDTH-1:0] act,
        input logic [DATA_WIDTH-1:0] wgt
    );
        logic signed [PROD_W-1:0] p;
        p = PROD_W'($signed({1'b0, act})) * PROD_W'($signed(wgt));
        return ACC_WIDTH'(p);
    endfunction

    assign term = mac_term(hid_q, rom_q);
    assign xfer = (state == S_OUT) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (j == J_LAST) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                state_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = (k == K_LAST) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Read data lags the address by one cycle, so FETCH at j accumulates the term for j-1
    // and DRAIN picks up the final one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            j        <= '0;
            acc      <= '0;
            rom_addr <= '0;
            hid_addr <= '0;
            out_idx  <= '0;
            out_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k        <= '0;
                        j        <= '0;
                        acc      <= '0;
                        rom_addr <= '0;
                        hid_addr <= '0;
                    end
                end
                S_FETCH: begin
                    if (j != '0) acc <= acc + term;
                    if (j != J_LAST) begin
                        j        <= j + 1'b1;
                        rom_addr <= rom_addr + 1'b1;
                        hid_addr <= hid_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    out_data <= acc + term;
                    out_idx  <= k;
                end
                S_OUT: begin
                    if (out_ready) begin
                        hid_addr <= '0;
                        if (k != K_LAST) begin
                            k        <= k + 1'b1;
                            j        <= '0;
                            acc      <= '0;
                            rom_addr <= rom_addr + 1'b1;
                        end else begin
                            rom_addr <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef OUTPUT_LAYER_CTRL_ARGMAX_EN
    logic signed [ACC_WIDTH-1:0] max_val;
    logic [IDX_W-1:0]            max_idx;
    logic [IDX_W-1:0]            pred_r;
    logic                        beats;

    // Strict compare so ties keep the earlier (lower) index.
    assign beats = $signed(out_data) > max_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val <= '0;
            max_idx <= '0;
            pred_r  <= '0;
        end else if (state == S_IDLE && start) begin
            max_val <= {1'b1, {(ACC_WIDTH-1){1'b0}}};
            max_idx <= '0;
        end else if (xfer) begin
            if (beats) begin
                max_val <= $signed(out_data);
                max_idx <= out_idx;
            end
            if (k == K_LAST) pred_r <= beats ? out_idx : max_idx;
        end
    end

    assign pred_idx = pred_r;
`else
    assign pred_idx = '0;
`endif

endmodule

// File: tb/tb_output_layer_ctrl.sv
// Scoreboard bench for output_layer_ctrl with synchronous ROM/hidden-memory models.
module tb_output_layer_ctrl;

    localparam int NH = 32;
    localparam int NO = 10;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int CW = 22;
    localparam int HW = 5;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic [HW-1:0] hid_addr;
    logic [DW-1:0] hid_q;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic [CW-1:0] out_data;
    logic [IW-1:0] pred_idx;

    output_layer_ctrl #(
        .NUM_HIDDEN(NH), .NUM_OUT(NO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_q(rom_q), .hid_addr(hid_addr), .hid_q(hid_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .pred_idx(pred_idx)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rom [0:(1<<AW)-1];
    logic [DW-1:0] hid [0:NH-1];

    always @(posedge clk) begin
        rom_q <= rom[rom_addr];
        hid_q <= hid[hid_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint got, input longint want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    longint exp_data_q[$];
    int     exp_idx_q[$];
    int     exp_cyc_q[$];
    int     exp_pred;
    int     exp_done_cyc;

    int     ec = 0;
    int     start_ec = 0;
    int     cyc;
    int     stall_lim = 0;
    int     stalled = 0;
    bit     addr_chk = 0;
    bit     saw_done = 0;
    int     dones = 0;
    bit     prev_xfer = 0;
    bit     have_hold = 0;
    logic [IW-1:0] hold_idx;
    logic [CW-1:0] hold_data;

    always @(posedge clk) ec <= ec + 1;

    task automatic load(input int mode);
        for (int kk = 0; kk < NO; kk++)
            for (int jj = 0; jj < NH; jj++) begin
                case (mode)
                    1: begin rom[kk*NH+jj] = 8'd1;   hid[jj] = 8'd255; end
                    2: begin rom[kk*NH+jj] = 8'h80;  hid[jj] = 8'd255; end
                    3: begin rom[kk*NH+jj] = 8'h7F;  hid[jj] = 8'd0;   end
                    4: begin rom[kk*NH+jj] = 8'(kk+1); hid[jj] = 8'(jj); end
                    5: begin rom[kk*NH+jj] = (kk == 7) ? 8'd2 : 8'd1; hid[jj] = 8'd1; end
                    default: begin rom[kk*NH+jj] = 8'd1; hid[jj] = 8'd1; end
                endcase
            end
    endtask

    task automatic push_expected(input int stall);
        longint best;
        best = 0;
        exp_pred = 0;
        for (int kk = 0; kk < NO; kk++) begin
            longint sum;
            sum = 0;
            for (int jj = 0; jj < NH; jj++) begin
                int w, h;
                w = int'($signed(rom[kk*NH+jj]));
                h = int'(hid[jj]);
                sum += longint'(w * h);
            end
            exp_data_q.push_back(sum);
            exp_idx_q.push_back(kk);
            exp_cyc_q.push_back(34*kk + 34 + ((kk >= 3) ? stall : 0));
            if (kk == 0 || sum > best) begin
                best = sum;
`ifdef OUTPUT_LAYER_CTRL_ARGMAX_EN
                exp_pred = kk;
`endif
            end
        end
        exp_done_cyc = 341 + stall;
    endtask

    // Ready generation and output checking share one process so their order is fixed.
    always @(negedge clk) begin
        cyc = ec - start_ec;
        if (stall_lim > 0 && out_valid && out_idx == 4'd3 && stalled < stall_lim) begin
            out_ready = 1'b0;
            stalled++;
        end else begin
            out_ready = 1'b1;
        end
        if (have_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_idx", out_idx, hold_idx);
            check("hold_data", longint'($signed(out_data)), longint'($signed(hold_data)));
            have_hold = 0;
        end
        if (prev_xfer) check("valid_drop", out_valid, 0);
        prev_xfer = 0;
        if (out_valid && out_ready) begin
            prev_xfer = 1;
            if (exp_data_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                check("out_idx", out_idx, exp_idx_q.pop_front());
                check("out_data", longint'($signed(out_data)), exp_data_q.pop_front());
                check("out_cycle", cyc, exp_cyc_q.pop_front());
            end
        end else if (out_valid) begin
            have_hold = 1;
            hold_idx  = out_idx;
            hold_data = out_data;
        end
        if (addr_chk && cyc >= 1 && cyc <= 340 && ((cyc-1) % 34) < 32) begin
            check("rom_addr", rom_addr, ((cyc-1)/34)*NH + ((cyc-1) % 34));
            check("hid_addr", hid_addr, (cyc-1) % 34);
        end
        if (done) begin
            saw_done = 1;
            dones++;
            check("done_cycle", cyc, exp_done_cyc);
            check("pred_idx", pred_idx, exp_pred);
            check("sb_empty", exp_data_q.size(), 0);
        end
    end

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_ec = ec - 1;
    endtask

    task automatic run(input int stall, input bit addr_chk_i, input bit start_at_done, input bit mid_start);
        push_expected(stall);
        stall_lim = stall;
        stalled   = 0;
        saw_done  = 0;
        dones     = 0;
        addr_chk  = addr_chk_i;
        kick();
        for (int i = 0; i < 420 && !saw_done; i++) begin
            @(negedge clk);
            #1;
            start = (mid_start && i == 100);
        end
        start = 1'b0;
        check("done_seen", saw_done, 1);
        if (start_at_done) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            check("start_in_done_busy", busy, 0);
        end
        repeat (3) @(negedge clk);
        check("done_count", dones, 1);
        addr_chk = 0;
        stall_lim = 0;
        exp_data_q.delete();
        exp_idx_q.delete();
        exp_cyc_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        load(1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_hid_addr", hid_addr, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_data", out_data, 0);
        check("rst_pred_idx", pred_idx, 0);
        @(negedge clk);
        rst = 1'b0;

        load(1); run(0, 0, 1, 0);
        load(2); run(0, 0, 0, 0);
        load(3); run(0, 0, 0, 0);
        load(4); run(0, 1, 0, 0);

        // Abandon a run mid-FETCH with an asynchronous reset.
        load(4);
        kick();
        repeat (10) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_rom_addr", rom_addr, 0);
        check("mid_rst_hid_addr", hid_addr, 0);
        run(0, 0, 0, 0);

        load(4); run(5, 0, 0, 1);
        load(5); run(0, 0, 0, 0);
        load(6); run(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/output_layer_ctrl.md
Name: output_layer_ctrl

Overview:
- Sequencer for the output layer of the digit-classifier network.
- Walks the output-weight ROM and the hidden-activation memory, multiplies each weight by its hidden activation, and accumulates one dot product per output neuron.
- Presents each neuron's result on a valid/ready interface to the downstream scorer.
- Sits between the hidden-layer result store and the classification/argmax stage.

Parameters:
- NUM_HIDDEN, 32: hidden activations per output neuron.
- NUM_OUT, 10: number of output neurons.
- ADDR_WIDTH, 9: weight ROM address width. Requires NUM_OUT*NUM_HIDDEN <= 2**ADDR_WIDTH.
- DATA_WIDTH, 8: weight and activation width.
- ACC_WIDTH, 22: accumulator width. Requires ACC_WIDTH >= 2*DATA_WIDTH+1+clog2(NUM_HIDDEN).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to run the output layer.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse when all NUM_OUT results have been accepted.
- rom_addr  output  ADDR_WIDTH  weight ROM address (registered).
- rom_q  input  DATA_WIDTH  weight ROM data, signed two's complement, 1-cycle synchronous read.
- hid_addr  output  clog2(NUM_HIDDEN)  hidden memory address (registered).
- hid_q  input  DATA_WIDTH  hidden activation, unsigned, 1-cycle synchronous read.
- out_valid  output  1  out_data/out_idx valid.
- out_ready  input  1  downstream accepts the result.
- out_idx  output  clog2(NUM_OUT)  output neuron index k.
- out_data  output  ACC_WIDTH  signed dot product for neuron k.
- pred_idx  output  clog2(NUM_OUT)  argmax result (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, out_valid, rom_addr, hid_addr, out_idx, out_data, pred_idx, accumulator and counters all 0.
- A reset mid-run abandons the run with no output; a later start begins a fresh run.
- Addressing:
  - rom_addr = k*NUM_HIDDEN + j (output-major weight layout).
  - hid_addr = j.
- Arithmetic:
  - Each product is {1'b0,hid_q} times signed rom_q, giving a (2*DATA_WIDTH+1)-bit signed value.
  - Products are sign-extended and summed into the ACC_WIDTH accumulator.
  - No saturation; parameter rules guarantee no overflow.
- State IDLE:
  - busy=0, addresses held 0.
  - start=1 -> FETCH with k=0, j=0, accumulator cleared.
  - start is ignored in every other state.
- State FETCH: one cycle per j=0..NUM_HIDDEN-1.
  - Addresses for j are on the ports in that cycle.
  - The product for j-1 (data returned this cycle) is accumulated, except in the j=0 cycle.
  - After j=NUM_HIDDEN-1 -> DRAIN.
- State DRAIN:
  - Accumulates the product for j=NUM_HIDDEN-1.
  - Loads out_data and out_idx=k -> OUT.
- State OUT:
  - out_valid=1; out_data and out_idx held stable while out_ready=0.
  - Transfer occurs on a cycle with out_valid&&out_ready.
  - If k<NUM_OUT-1: k++, j=0, accumulator cleared -> FETCH.
  - Else -> DONE.
  - out_valid deasserts the cycle after the transfer.
- State DONE:
  - done=1 for exactly one cycle, then -> IDLE.
- busy=1 from the cycle after start is accepted through the DONE cycle inclusive.
- Timing with out_ready held high, start sampled at edge 0:
  - Neuron k occupies cycles 34k+1..34k+34 (FETCH 32 cycles, DRAIN 1, OUT 1).
  - done is high in cycle 341.
  - Each cycle out_ready is low in OUT delays all later events by one cycle.
- A start pulse in the same cycle as done is ignored (state is DONE, not IDLE).

Optional Feature:
- Macro: OUTPUT_LAYER_CTRL_ARGMAX_EN.
- Defined:
  - Block tracks a running maximum of out_data (signed) and its index over each transferred result.
  - The tracker resets at start.
  - Ties keep the lower index.
  - pred_idx updates in the DONE cycle and holds until the next DONE or reset.
- Undefined: pred_idx tied to 0 and no tracking logic is built.

Test Plan:
- Reset during FETCH at cycle 10 -> next cycle: busy=0, out_valid=0, rom_addr=0, hid_addr=0. A new start then gives out_idx=0 first with the correct sum.
- All weights=1, all hidden=255, out_ready=1, start at edge 0 -> ten results, each out_data=8160, out_idx=0..9, each out_valid one cycle. Results appear in cycles 34,68,...,340; done pulses in cycle 341.
- Weights=-128 (0x80), hidden=255 -> every out_data=-1044480. Weights=0x7F with hidden=0 -> out_data=0.
- Neuron k: weight[k][j]=k+1, hidden[j]=j -> out_data=(k+1)*496. Also check rom_addr sequence 0..319, with hid_addr cycling 0..31 ten times.
- out_ready low for 5 cycles while out_idx=3 -> out_valid, out_idx=3 and out_data stable throughout. done moves to cycle 346. A start pulse mid-run changes nothing.
- ARGMAX_EN defined, neuron 7 weights=2, others=1, hidden=1 -> pred_idx=7 at done. All neurons equal -> pred_idx=0.
